// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x3 matrix keypad scanner with debounced press/release.
// Columns are driven active-low one at a time; rows are sampled once per
// column dwell (sample tick). Auto-repeat of KEY_VALID while a key is held
// is built in only when the macro KEYPAD_REPEAT_EN is defined.
//
// state       | meaning
// ST_SCAN     | rotating columns, waiting for any row low on a tick
// ST_DEBOUNCE | column frozen, counting consecutive matching press samples
// ST_PRESSED  | key accepted, KEY_HELD high, waiting for row to go high
// ST_RELEASE  | counting consecutive high samples before declaring release
module keypad_scanner #(
  parameter int SCAN_DIV      = 3333,
  parameter int DEBOUNCE_CNT  = 20,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       KEYPAD_ROW_0,
  input  logic       KEYPAD_ROW_1,
  input  logic       KEYPAD_ROW_2,
  input  logic       KEYPAD_ROW_3,
  output logic       KEYPAD_COL_0,
  output logic       KEYPAD_COL_1,
  output logic       KEYPAD_COL_2,
  output logic [3:0] KEY_CODE,
  output logic       KEY_VALID,
  output logic       KEY_HELD
);

  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_PRESSED, ST_RELEASE} state_t;

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  DB_LAST  = 8'(DEBOUNCE_CNT);

  function automatic logic [3:0] code_of(input logic [1:0] r, input logic [1:0] c);
    return ({2'b00, r} << 1) + {2'b00, r} + {2'b00, c};
  endfunction

  logic [3:0] row_meta_q, row_sync_q;
  logic [15:0] div_q;
  logic        tick;
  state_t      state_q, state_d;
  logic [1:0]  col_idx_q, col_idx_d;
  logic [2:0]  col_drv_q, col_drv_d;
  logic [1:0]  row_q, row_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic [3:0]  code_q, code_d;
  logic        valid_q, valid_d;
  logic        held_q, held_d;
  logic        advance;
  logic        any_low;
  logic [1:0]  low_row;
  logic        row_high;

`ifdef KEYPAD_REPEAT_EN
  logic [15:0] rep_q, rep_d;
`else
  // Repeat timing parameters are meaningless without the auto-repeat build.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  // Two-flop synchronizer on the asynchronous row inputs (idle high).
  always_ff @(posedge CLK) begin
    if (RST) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= {KEYPAD_ROW_3, KEYPAD_ROW_2, KEYPAD_ROW_1, KEYPAD_ROW_0};
      row_sync_q <= row_meta_q;
    end
  end

  // Free-running dwell divider; the tick is its terminal count.
  always_ff @(posedge CLK) begin
    if (RST) div_q <= '0;
    else     div_q <= tick ? '0 : div_q + 16'd1;
  end

  assign tick     = (div_q == DIV_LAST);
  assign cnt_inc  = cnt_q + 8'd1;
  assign row_high = row_sync_q[row_q];

  // Priority pick of the lowest-numbered low row.
  always_comb begin
    any_low = 1'b0;
    low_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync_q[r]) begin
        any_low = 1'b1;
        low_row = 2'(r);
      end
    end
  end

  // Next-state, column advance and output strobes.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    advance = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d   = rep_q;
`endif
    case (state_q)
      ST_SCAN: if (tick) begin
        if (any_low) begin
          row_d = low_row;
          cnt_d = 8'd1;
          if (DB_LAST == 8'd1) begin
            state_d = ST_PRESSED;
            code_d  = code_of(low_row, col_idx_q);
            valid_d = 1'b1;
            held_d  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
            rep_d   = 16'(REPEAT_DELAY);
`endif
          end else begin
            state_d = ST_DEBOUNCE;
          end
        end else begin
          advance = 1'b1;
        end
      end
      ST_DEBOUNCE: if (tick) begin
        if (any_low && (low_row == row_q)) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DB_LAST) begin
            state_d = ST_PRESSED;
            code_d  = code_of(row_q, col_idx_q);
            valid_d = 1'b1;
            held_d  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
            rep_d   = 16'(REPEAT_DELAY);
`endif
          end
        end else begin
          state_d = ST_SCAN;
          advance = 1'b1;
        end
      end
      ST_PRESSED: if (tick) begin
        if (row_high) begin
          cnt_d = 8'd1;
          if (DB_LAST == 8'd1) begin
            state_d = ST_SCAN;
            held_d  = 1'b0;
            advance = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end
`ifdef KEYPAD_REPEAT_EN
        else if (rep_q == 16'd1) begin
          valid_d = 1'b1;
          rep_d   = 16'(REPEAT_PERIOD);
        end else begin
          rep_d = rep_q - 16'd1;
        end
`endif
      end
      ST_RELEASE: if (tick) begin
        if (row_high) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DB_LAST) begin
            state_d = ST_SCAN;
            held_d  = 1'b0;
            advance = 1'b1;
          end
        end else begin
          state_d = ST_PRESSED;
        end
      end
      default: state_d = ST_SCAN;
    endcase
    col_idx_d = advance ? ((col_idx_q == 2'd2) ? 2'd0 : col_idx_q + 2'd1) : col_idx_q;
    col_drv_d = ~(3'b001 << col_idx_d);
  end

  // State, column drive and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_SCAN;
      col_idx_q <= 2'd0;
      col_drv_q <= 3'b110;
      row_q     <= 2'd0;
      cnt_q     <= 8'd0;
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      col_drv_q <= col_drv_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  // Auto-repeat down-counter; only moves on PRESSED ticks, frozen elsewhere.
  always_ff @(posedge CLK) begin
    if (RST) rep_q <= '0;
    else     rep_q <= rep_d;
  end
`endif

  assign KEYPAD_COL_0 = col_drv_q[0];
  assign KEYPAD_COL_1 = col_drv_q[1];
  assign KEYPAD_COL_2 = col_drv_q[2];
  assign KEY_CODE     = code_q;
  assign KEY_VALID    = valid_q;
  assign KEY_HELD     = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: a key-matrix model closes rows onto driven
// columns; expected strobe times/codes come from tick arithmetic.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 3;
  localparam int RD = 5;
  localparam int RP = 2;
`ifdef KEYPAD_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [3:0] rows;
  logic COL_0, COL_1, COL_2;
  logic [3:0] KEY_CODE;
  logic KEY_VALID, KEY_HELD;

  logic [3:0] kmask [3];

  int cur = 0;
  int n_pass = 0;
  int n_total = 0;

  int strobe_cyc[$];
  int strobe_code[$];
  int held_rise = -1;
  int held_fall = -1;
  int n_falls = 0;
  logic held_prev = 1'b0;

  always #5 CLK = ~CLK;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .CLK(CLK), .RST(RST),
    .KEYPAD_ROW_0(rows[0]), .KEYPAD_ROW_1(rows[1]), .KEYPAD_ROW_2(rows[2]), .KEYPAD_ROW_3(rows[3]),
    .KEYPAD_COL_0(COL_0), .KEYPAD_COL_1(COL_1), .KEYPAD_COL_2(COL_2),
    .KEY_CODE(KEY_CODE), .KEY_VALID(KEY_VALID), .KEY_HELD(KEY_HELD)
  );

  // Physical matrix: a closed switch pulls its row low when its column is driven low.
  always_comb begin
    for (int r = 0; r < 4; r++)
      rows[r] = ~((kmask[0][r] & ~COL_0) | (kmask[1][r] & ~COL_1) | (kmask[2][r] & ~COL_2));
  end

  // Strobe / held monitor, sampled mid-cycle.
  always @(negedge CLK) begin
    if (RST) begin
      held_prev = 1'b0;
      held_rise = -1;
      held_fall = -1;
      n_falls   = 0;
      strobe_cyc.delete();
      strobe_code.delete();
    end else begin
      if (KEY_VALID) begin
        strobe_cyc.push_back(cur);
        strobe_code.push_back(int'(KEY_CODE));
      end
      if (KEY_HELD && !held_prev && held_rise < 0) held_rise = cur;
      if (!KEY_HELD && held_prev) begin
        held_fall = cur;
        n_falls++;
      end
      held_prev = KEY_HELD;
    end
  end

  task automatic wait_cycle();
    @(posedge CLK);
    #1;
    cur++;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    wait_cycle();
    wait_cycle();
    RST = 1'b0;
    cur = 0;
  endtask

  function automatic logic [2:0] col_exp(input int idx);
    logic [2:0] one;
    one = 3'b001;
    return ~(one << idx);
  endfunction

  task automatic test_reset();
    for (int c = 0; c < 3; c++) kmask[c] = 4'b0000;
    do_reset();
    n_total++;
    if ({KEY_HELD, KEY_VALID, KEY_CODE, COL_2, COL_1, COL_0} !== {1'b0, 1'b0, 4'd0, 3'b110})
      $display("FAIL reset_outputs: got %b expected %b",
               {KEY_HELD, KEY_VALID, KEY_CODE, COL_2, COL_1, COL_0}, {1'b0, 1'b0, 4'd0, 3'b110});
    else n_pass++;
    while (cur < 24) begin
      n_total++;
      if ({COL_2, COL_1, COL_0} !== col_exp((cur / SD) % 3))
        $display("FAIL idle_scan_col cycle %0d: got %b expected %b", cur, {COL_2, COL_1, COL_0}, col_exp((cur / SD) % 3));
      else n_pass++;
      wait_cycle();
    end
    n_total++;
    if (strobe_cyc.size() != 0 || KEY_CODE !== 4'd0)
      $display("FAIL idle_no_strobe: got %0d strobes code %0d expected 0 strobes code 0", strobe_cyc.size(), KEY_CODE);
    else n_pass++;
  endtask

  // Press keys rmask on column c from tick window kp, hold `hold` ticks past
  // acceptance, optional one-tick release bounce boff ticks after acceptance.
  task automatic run_press(input logic [3:0] rmask, input int c, input int kp, input int hold,
                           input int boff, input string name);
    int kd, ka, kr, kb, end_cyc, low, j, w;
    int exp_cyc[$];
    int exp_code;
    for (int i = 0; i < 3; i++) if (i != c) kmask[i] = 4'b0000;
    do_reset();
    kd = kp;
    while (kd % 3 != c) kd++;
    ka = kd + DB - 1;
    kr = ka + 1 + hold;
    kb = (boff > 0) ? ka + boff : -10;
    low = 0;
    for (int r = 3; r >= 0; r--) if (rmask[r]) low = r;
    exp_code = low * 3 + c;
    exp_cyc.push_back(SD * ka + SD);
    if (REP_EN) begin
      j = 0;
      for (int k = ka + 1; k < kr; k++) begin
        if (k != kb && k != kb + 1) begin
          j++;
          if (j == RD || (j > RD && (j - RD) % RP == 0)) exp_cyc.push_back(SD * k + SD);
        end
      end
    end
    end_cyc = SD * (kr + DB - 1) + 3 * SD;
    while (cur < end_cyc) begin
      w = cur / SD;
      kmask[c] = (w >= kp && w < kr && w != kb) ? rmask : 4'b0000;
      wait_cycle();
    end
    kmask[c] = 4'b0000;
    n_total++;
    if (strobe_cyc.size() != exp_cyc.size())
      $display("FAIL %s strobe_count: got %0d expected %0d", name, strobe_cyc.size(), exp_cyc.size());
    else n_pass++;
    for (int i = 0; i < exp_cyc.size() && i < strobe_cyc.size(); i++) begin
      n_total++;
      if (strobe_cyc[i] != exp_cyc[i] || strobe_code[i] != exp_code)
        $display("FAIL %s strobe[%0d]: got cycle %0d code %0d expected cycle %0d code %0d",
                 name, i, strobe_cyc[i], strobe_code[i], exp_cyc[i], exp_code);
      else n_pass++;
    end
    n_total++;
    if (held_rise != SD * ka + SD || held_fall != SD * (kr + DB - 1) + SD || n_falls != 1)
      $display("FAIL %s held: got rise %0d fall %0d falls %0d expected rise %0d fall %0d falls 1",
               name, held_rise, held_fall, n_falls, SD * ka + SD, SD * (kr + DB - 1) + SD);
    else n_pass++;
    n_total++;
    if (int'(KEY_CODE) != exp_code)
      $display("FAIL %s code_hold: got %0d expected %0d", name, KEY_CODE, exp_code);
    else n_pass++;
  endtask

  task automatic test_single_press();
    run_press(4'b0100, 1, 0, 3, 0, "row2_col1");
  endtask

  task automatic test_multi_row();
    run_press(4'b1010, 2, 1, 2, 0, "rows13_col2");
  endtask

  task automatic test_release_bounce();
    run_press(4'b0001, 0, 2, 6, 2, "release_bounce");
  endtask

  task automatic test_repeat_hold();
    run_press(4'b1000, 0, 0, 12, 0, "hold_12_ticks");
  endtask

  task automatic test_glitch();
    int c, kd, end_cyc;
    c = int'($urandom_range(0, 2));
    for (int i = 0; i < 3; i++) kmask[i] = 4'b0000;
    do_reset();
    kd = c + 3;
    end_cyc = SD * (kd + 1) + 3 * SD;
    while (cur < end_cyc) begin
      kmask[c] = ((cur / SD) == kd) ? 4'b0001 : 4'b0000;
      if (cur == SD * kd + 5) begin
        n_total++;
        if ({COL_2, COL_1, COL_0} !== col_exp(c))
          $display("FAIL glitch_col_hold: got %b expected %b", {COL_2, COL_1, COL_0}, col_exp(c));
        else n_pass++;
      end
      if (cur == SD * (kd + 1) + SD) begin
        n_total++;
        if ({COL_2, COL_1, COL_0} !== col_exp((c + 1) % 3))
          $display("FAIL glitch_col_resume: got %b expected %b", {COL_2, COL_1, COL_0}, col_exp((c + 1) % 3));
        else n_pass++;
      end
      wait_cycle();
    end
    kmask[c] = 4'b0000;
    n_total++;
    if (strobe_cyc.size() != 0 || held_rise != -1)
      $display("FAIL glitch_no_strobe: got %0d strobes held_rise %0d expected 0 strobes held_rise -1",
               strobe_cyc.size(), held_rise);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    for (int i = 0; i < 3; i++) kmask[i] = 4'b0000;
    do_reset();
    kmask[1] = 4'b0100;
    while (cur < 18) wait_cycle();
    do_reset();
    n_total++;
    if ({KEY_HELD, KEY_VALID, KEY_CODE, COL_2, COL_1, COL_0} !== {1'b0, 1'b0, 4'd0, 3'b110})
      $display("FAIL reset_mid_pressed: got %b expected %b",
               {KEY_HELD, KEY_VALID, KEY_CODE, COL_2, COL_1, COL_0}, {1'b0, 1'b0, 4'd0, 3'b110});
    else n_pass++;
    while (cur < 10) wait_cycle();
    n_total++;
    if (strobe_cyc.size() != 0 || KEY_HELD !== 1'b0)
      $display("FAIL pre_abort_debounce: got %0d strobes held %b expected 0 strobes held 0", strobe_cyc.size(), KEY_HELD);
    else n_pass++;
    RST = 1'b1;
    wait_cycle();
    n_total++;
    if ({KEY_HELD, KEY_VALID, KEY_CODE, COL_2, COL_1, COL_0} !== {1'b0, 1'b0, 4'd0, 3'b110})
      $display("FAIL reset_mid_debounce: got %b expected %b",
               {KEY_HELD, KEY_VALID, KEY_CODE, COL_2, COL_1, COL_0}, {1'b0, 1'b0, 4'd0, 3'b110});
    else n_pass++;
    run_press(4'b0100, 1, 0, 3, 0, "redetect_after_reset");
  endtask

  task automatic test_random();
    logic [3:0] rmask;
    int c, kp, hold, boff;
    for (int it = 0; it < 6; it++) begin
      c     = int'($urandom_range(0, 2));
      rmask = 4'($urandom_range(1, 15));
      kp    = int'($urandom_range(0, 5));
      hold  = int'($urandom_range(0, 13));
      boff  = (hold >= 3 && ($urandom % 2) == 1) ? int'($urandom_range(1, hold - 1)) : 0;
      run_press(rmask, c, kp, hold, boff, "random_press");
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) kmask[i] = 4'b0000;
    test_reset();
    test_single_press();
    test_glitch();
    test_multi_row();
    test_release_bounce();
    test_reset_abort();
    test_repeat_hold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 3333, clock cycles per column dwell (1 ms at 3.33 MHz); legal range 4..65535.
REQ-002 Parameter DEBOUNCE_CNT, default 20, consecutive matching samples needed to accept a press or release; legal range 1..255.
REQ-003 Parameter REPEAT_DELAY, default 500, samples from accepted press to first auto-repeat (used only with KEYPAD_REPEAT_EN).
REQ-004 Parameter REPEAT_PERIOD, default 100, samples between subsequent auto-repeats (used only with KEYPAD_REPEAT_EN).
REQ-005 CLK  input  1  system clock; all logic on rising edge.
REQ-006 RST  input  1  synchronous, active-high reset.
REQ-007 KEYPAD_ROW_0..KEYPAD_ROW_3  input  1 each  row lines, active-low, pulled up externally by SB_IO, asynchronous to CLK.
REQ-008 KEYPAD_COL_0..KEYPAD_COL_2  output  1 each  column drives; selected column 0, others 1.
REQ-009 KEY_CODE  output  4  code of the accepted key, row*3+col, range 0..11.
REQ-010 KEY_VALID  output  1  one-cycle strobe; KEY_CODE is valid in that cycle.
REQ-011 KEY_HELD  output  1  high while an accepted key is pressed, including release debounce.

Function
REQ-012 Each row input SHALL pass through a 2-flop synchronizer before use; all decisions use the synchronized value.
REQ-013 A free-running divider SHALL count 0..SCAN_DIV-1, and a sample tick SHALL occur in the cycle where the count equals SCAN_DIV-1.
REQ-014 Column drive SHALL be registered and change only in the cycle after a tick, giving a full dwell of settling before the next sample.
REQ-015 FSM states SHALL be SCAN, DEBOUNCE, PRESSED and RELEASE.
REQ-016 SCAN, on a tick with any synchronized row low: latch the lowest-numbered low row and the current column, set count=1 and go to DEBOUNCE; otherwise advance the column 0->1->2->0.
REQ-017 DEBOUNCE holds the column; on a tick with the latched row still lowest low, increment the count.
REQ-018 DEBOUNCE, on reaching DEBOUNCE_CNT: go to PRESSED, load KEY_CODE, pulse KEY_VALID for exactly one cycle and set KEY_HELD.
REQ-019 DEBOUNCE, on any mismatching tick: return to SCAN and advance the column; no strobe.
REQ-020 DEBOUNCE_CNT=1 SHALL accept the press on the first tick that detects it.
REQ-021 PRESSED holds the column; on a tick with the latched row high, set count=1 and go to RELEASE.
REQ-022 RELEASE, on a tick with the row high, increment the count; on reaching DEBOUNCE_CNT, clear KEY_HELD, go to SCAN and advance the column.
REQ-023 RELEASE, on a tick with the row low again, return to PRESSED with no new KEY_VALID.
REQ-024 Multiple rows low on the same column SHALL resolve to the lowest row; keys on other columns are ignored until return to SCAN.
REQ-025 KEY_CODE SHALL hold its last value between strobes.
REQ-026 Strobe latency from the first detecting tick SHALL be (DEBOUNCE_CNT-1)*SCAN_DIV+1 cycles.

Reset
REQ-027 While RST is high at a clock edge, the following SHALL take effect:
  - state=SCAN, column index 0, so COL_0=0, COL_1=1, COL_2=1;
  - divider, debounce and repeat counters = 0;
  - KEY_CODE=0, KEY_VALID=0, KEY_HELD=0;
  - synchronizer flops=1.
REQ-028 Reset asserted mid-DEBOUNCE, PRESSED or RELEASE SHALL abort without a strobe.
REQ-029 After reset, a key still held SHALL be re-detected and strobed once after full debounce.

Configuration
REQ-030 With macro KEYPAD_REPEAT_EN defined:
  - in PRESSED, a repeat counter counts ticks;
  - KEY_VALID re-pulses with an unchanged KEY_CODE after REPEAT_DELAY ticks, then every REPEAT_PERIOD ticks;
  - the counter clears on entry to PRESSED from DEBOUNCE and is frozen in RELEASE.
REQ-031 Without KEYPAD_REPEAT_EN, no repeat logic SHALL be synthesized, and exactly one strobe SHALL occur per accepted press.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_DELAY=5, REPEAT_PERIOD=2)
REQ-032 Reset, no keys -> COL_0..2 cycle 011,101,110 every 4 clocks; KEY_VALID never asserts; KEY_CODE=0.
REQ-033 ROW_2 held low while COL_1 is driven low -> single KEY_VALID with KEY_CODE=7 nine cycles after the detecting tick; KEY_HELD=1 until 3 high samples after release.
REQ-034 ROW_0 low for one tick only (glitch) -> no KEY_VALID; scan resumes at the next column.
REQ-035 ROW_1 and ROW_3 low on COL_2 -> KEY_CODE=5.
REQ-036 Release bounce (1 high tick, then low) -> returns to PRESSED; no second strobe; KEY_HELD stays 1.
REQ-037 RST pulsed mid-DEBOUNCE with the key held -> outputs at reset values; one strobe after a fresh 3-sample debounce.
REQ-038 With KEYPAD_REPEAT_EN, key held 12 ticks past acceptance -> strobes at acceptance and at ticks 5, 7, 9 and 11; without the macro -> one strobe.
